// File: rtl/stage_sequencer_if.sv
// Signal bundle between the Beta CPU datapath and its pipeline sequencer.
// The datapath side drives instructions and Ra data; the sequencer side drives enables and status.
interface stage_sequencer_if;
  logic        alive;
  logic [31:0] instr_rfr;
  logic [31:0] instr_alu;
  logic [31:0] instr_dm;
  logic [31:0] instr_rfw;
  logic [31:0] pc_addr;
  logic [4:0]  stage_en;
  logic [1:0]  pcsel;
  logic        bubble;
  logic        squash;
  logic        halted;
  logic [15:0] stall_count;

  modport master (
    output alive, instr_rfr, instr_alu, instr_dm, instr_rfw, pc_addr,
    input  stage_en, pcsel, bubble, squash, halted, stall_count
  );

  modport slave (
    input  alive, instr_rfr, instr_alu, instr_dm, instr_rfw, pc_addr,
    output stage_en, pcsel, bubble, squash, halted, stall_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Five-stage Beta pipeline sequencer: RAW stall, branch resolution in RFR, HALT drain.
// Stage enables and PC select are Mealy outputs; state, halted and stall count are registered.
module stage_sequencer (
  input  logic              clk,
  input  logic              rst,
  stage_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LD   = 6'h18;
  localparam logic [5:0] OP_ST   = 6'h19;
  localparam logic [5:0] OP_JMP  = 6'h1B;
  localparam logic [5:0] OP_BEQ  = 6'h1C;
  localparam logic [5:0] OP_BNE  = 6'h1D;
  localparam logic [5:0] OP_LDR  = 6'h1F;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_STALL = 5'b11100;
  localparam logic [4:0] EN_HALT  = 5'b11110;

  function automatic logic is_writer(input logic [5:0] op);
    is_writer = (op == OP_LD) ||
                ((op >= OP_JMP) && (op <= OP_BNE)) ||
                (op == OP_LDR) ||
                ((op >= 6'h20) && (op <= 6'h3E));
  endfunction

  function automatic logic writes_reg(input logic [31:0] instr, input logic [4:0] r);
    writes_reg = is_writer(instr[31:26]) && (instr[25:21] == r);
  endfunction

  // Register 31 reads as zero and is never a real dependency.
  function automatic logic src_hit(input logic [4:0] r, input logic [31:0] alu,
                                   input logic [31:0] dm, input logic [31:0] rfw);
    src_hit = (r != 5'd31) &&
              (writes_reg(alu, r) || writes_reg(dm, r) || writes_reg(rfw, r));
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic        halted_r;
  logic [15:0] stall_count_r;

  logic [5:0]  op_s;
  logic        ra_used_s;
  logic        rb_used_s;
  logic        rc_used_s;
  logic        hazard_s;
  logic [4:0]  stage_en_s;
  logic [1:0]  pcsel_s;
  logic        bubble_s;
  logic        squash_s;
  logic        stall_inc_s;
  logic        count_clr_s;

  assign op_s      = bus.instr_rfr[31:26];
  assign ra_used_s = (op_s != OP_NOP) && (op_s != OP_HALT);
  assign rb_used_s = (op_s >= 6'h20) && (op_s <= 6'h2F);
  assign rc_used_s = (op_s == OP_ST);

  assign hazard_s =
    (ra_used_s && src_hit(bus.instr_rfr[20:16], bus.instr_alu, bus.instr_dm, bus.instr_rfw)) ||
    (rb_used_s && src_hit(bus.instr_rfr[15:11], bus.instr_alu, bus.instr_dm, bus.instr_rfw)) ||
    (rc_used_s && src_hit(bus.instr_rfr[25:21], bus.instr_alu, bus.instr_dm, bus.instr_rfw));

  // Next-state and Mealy outputs; alive low overrides everything except reset.
  always_comb begin
    next_state_s = state_r;
    stage_en_s   = 5'b00000;
    pcsel_s      = 2'b00;
    bubble_s     = 1'b0;
    squash_s     = 1'b0;
    stall_inc_s  = 1'b0;
    count_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.alive) begin
          next_state_s = RUN;
          count_clr_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (!bus.alive) begin
          next_state_s = IDLE;
        end else if (hazard_s) begin
          stage_en_s  = EN_STALL;
          bubble_s    = 1'b1;
          stall_inc_s = 1'b1;
        end else if (op_s == OP_HALT) begin
          stage_en_s   = EN_HALT;
          squash_s     = 1'b1;
          next_state_s = DRAIN;
        end else begin
          stage_en_s = EN_ALL;
          case (op_s)
            OP_JMP: begin
              pcsel_s  = 2'b10;
              squash_s = 1'b1;
            end
            OP_BEQ: begin
              pcsel_s  = 2'b01;
              squash_s = (bus.pc_addr == 32'h0000_0000);
            end
            OP_BNE: begin
              pcsel_s  = 2'b11;
              squash_s = (bus.pc_addr != 32'h0000_0000);
            end
            default: begin
              pcsel_s = 2'b00;
            end
          endcase
        end
      end
      DRAIN: begin
        if (!bus.alive) begin
          next_state_s = IDLE;
        end else begin
          stage_en_s = EN_STALL;
          if (bus.instr_rfw[31:26] == OP_HALT) begin
            next_state_s = HALTED;
          end else begin
            next_state_s = DRAIN;
          end
        end
      end
      HALTED: begin
        if (!bus.alive) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HALTED;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, halted flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      halted_r      <= 1'b0;
      stall_count_r <= 16'h0000;
    end else begin
      state_r  <= next_state_s;
      halted_r <= (next_state_s == HALTED);
      if (count_clr_s) begin
        stall_count_r <= 16'h0000;
      end else if (stall_inc_s && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'h0001;
      end
    end
  end

  assign bus.stage_en    = stage_en_s;
  assign bus.pcsel       = pcsel_s;
  assign bus.bubble      = bubble_s;
  assign bus.squash      = squash_s;
  assign bus.halted      = halted_r;
  assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scenario bench for stage_sequencer: expected output words are queued as vectors are driven
// and compared against the captured DUT outputs at the end of each scenario.
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_sequencer_if bus ();

  stage_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] HALT     = 32'hFC00_0000;
  localparam logic [4:0]  EN_ALL   = 5'b11111;
  localparam logic [4:0]  EN_STALL = 5'b11100;
  localparam logic [4:0]  EN_HALT  = 5'b11110;
  localparam logic [4:0]  EN_OFF   = 5'b00000;

  int vectors = 0;
  int miscompares = 0;
  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];

  function automatic logic [31:0] op3(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'h000};
  endfunction

  function automatic logic [31:0] opl(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra);
    return {op, rc, ra, 16'h0004};
  endfunction

  // One cycle: apply inputs after the edge, queue expectation, capture outputs mid-cycle.
  task automatic drive(input logic r, input logic a, input logic [31:0] rfr, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [31:0] rfw, input logic [31:0] pc,
                       input logic [4:0] en, input logic [1:0] ps, input logic bub,
                       input logic sq, input logic hlt, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    rst           = r;
    bus.alive     = a;
    bus.instr_rfr = rfr;
    bus.instr_alu = alu;
    bus.instr_dm  = dm;
    bus.instr_rfw = rfw;
    bus.pc_addr   = pc;
    exp_q.push_back({en, ps, bub, sq, hlt, cnt});
    @(negedge clk);
    obs_q.push_back({bus.stage_en, bus.pcsel, bus.bubble, bus.squash, bus.halted, bus.stall_count});
  endtask

  task automatic test_reset();
    int n = 0;
    logic [25:0] e, o;
    drive(1'b1, 1'b1, NOP, NOP, NOP, NOP, 32'h0, EN_OFF, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, NOP, NOP, NOP, NOP, 32'h0, EN_OFF, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, NOP, NOP, NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_independent();
    int n = 0;
    logic [25:0] e, o;
    drive(1'b0, 1'b1, op3(6'h20, 5'd1, 5'd4, 5'd5), NOP, NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, op3(6'h20, 5'd2, 5'd6, 5'd7), op3(6'h20, 5'd1, 5'd4, 5'd5), NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, NOP, op3(6'h20, 5'd2, 5'd6, 5'd7), op3(6'h20, 5'd1, 5'd4, 5'd5), NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    // A store in ALU names r6 in its Rc field but does not write it.
    drive(1'b0, 1'b1, op3(6'h20, 5'd10, 5'd6, 5'd7), opl(6'h19, 5'd6, 5'd1), NOP, op3(6'h20, 5'd1, 5'd4, 5'd5), 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL independent #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_raw_stall();
    int n = 0;
    logic [25:0] e, o;
    logic [31:0] rd, wr;
    rd = op3(6'h20, 5'd8, 5'd3, 5'd9);
    wr = op3(6'h20, 5'd3, 5'd1, 5'd2);
    drive(1'b0, 1'b1, rd, wr,  NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, rd, NOP, wr,  NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0001);
    drive(1'b0, 1'b1, rd, NOP, NOP, wr,  32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0002);
    drive(1'b0, 1'b1, rd, NOP, NOP, NOP, 32'h0, EN_ALL,   2'b00, 1'b0, 1'b0, 1'b0, 16'h0003);
    drive(1'b0, 1'b1, NOP, rd, NOP, NOP, 32'h0, EN_ALL,   2'b00, 1'b0, 1'b0, 1'b0, 16'h0003);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL raw_stall #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_r31_and_sources();
    int n = 0;
    logic [25:0] e, o;
    drive(1'b0, 1'b1, op3(6'h20, 5'd8, 5'd31, 5'd9), op3(6'h20, 5'd31, 5'd1, 5'd2), NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0003);
    drive(1'b0, 1'b1, opl(6'h19, 5'd5, 5'd6), NOP, NOP, opl(6'h18, 5'd5, 5'd7), 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0003);
    drive(1'b0, 1'b1, opl(6'h19, 5'd5, 5'd6), NOP, NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0004);
    drive(1'b0, 1'b1, op3(6'h20, 5'd10, 5'd11, 5'd12), NOP, opl(6'h1C, 5'd12, 5'd1), NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0004);
    drive(1'b0, 1'b1, op3(6'h20, 5'd10, 5'd11, 5'd12), NOP, NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0005);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL r31_sources #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_branches();
    int n = 0;
    logic [25:0] e, o;
    drive(1'b0, 1'b1, opl(6'h1C, 5'd31, 5'd2), NOP, NOP, NOP, 32'h0, EN_ALL, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0005);
    drive(1'b0, 1'b1, opl(6'h1C, 5'd31, 5'd2), NOP, NOP, NOP, 32'h5, EN_ALL, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0005);
    drive(1'b0, 1'b1, opl(6'h1B, 5'd31, 5'd3), NOP, NOP, NOP, 32'h5, EN_ALL, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0005);
    drive(1'b0, 1'b1, opl(6'h1D, 5'd31, 5'd2), NOP, NOP, NOP, 32'h0, EN_ALL, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0005);
    drive(1'b0, 1'b1, opl(6'h1D, 5'd31, 5'd2), NOP, NOP, NOP, 32'h8000_0000, EN_ALL, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0005);
    drive(1'b0, 1'b1, op3(6'h20, 5'd1, 5'd2, 5'd3), NOP, NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0005);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL branches #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_hazard_beats_branch();
    int n = 0;
    logic [25:0] e, o;
    logic [31:0] bne, wr;
    bne = opl(6'h1D, 5'd31, 5'd4);
    wr  = op3(6'h20, 5'd4, 5'd1, 5'd2);
    drive(1'b0, 1'b1, bne, NOP, wr,  NOP, 32'h9, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0005);
    drive(1'b0, 1'b1, bne, NOP, NOP, wr,  32'h9, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0006);
    drive(1'b0, 1'b1, bne, NOP, NOP, NOP, 32'h9, EN_ALL,   2'b11, 1'b0, 1'b1, 1'b0, 16'h0007);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL hazard_branch #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_halt();
    int n = 0;
    logic [25:0] e, o;
    drive(1'b0, 1'b1, HALT, NOP, NOP, NOP, 32'h0, EN_HALT, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0007);
    // Drain ignores what looks like a RAW dependency.
    drive(1'b0, 1'b1, op3(6'h20, 5'd8, 5'd3, 5'd9), HALT, op3(6'h20, 5'd3, 5'd1, 5'd2), NOP, 32'h0, EN_STALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0007);
    drive(1'b0, 1'b1, NOP, NOP, HALT, NOP, 32'h0, EN_STALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0007);
    drive(1'b0, 1'b1, NOP, NOP, NOP, HALT, 32'h0, EN_STALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0007);
    drive(1'b0, 1'b1, NOP, NOP, NOP, NOP, 32'h0, EN_OFF, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0007);
    drive(1'b0, 1'b1, opl(6'h1C, 5'd31, 5'd2), NOP, NOP, NOP, 32'h0, EN_OFF, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0007);
    drive(1'b0, 1'b0, NOP, NOP, NOP, NOP, 32'h0, EN_OFF, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0007);
    drive(1'b0, 1'b0, NOP, NOP, NOP, NOP, 32'h0, EN_OFF, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0007);
    drive(1'b0, 1'b1, NOP, NOP, NOP, NOP, 32'h0, EN_OFF, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0007);
    drive(1'b0, 1'b1, NOP, NOP, NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL halt #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    logic [25:0] e, o;
    logic [31:0] rd, wr;
    rd = op3(6'h20, 5'd8, 5'd3, 5'd9);
    wr = op3(6'h20, 5'd3, 5'd1, 5'd2);
    drive(1'b0, 1'b1, rd, wr, NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (65533) @(posedge clk);
    drive(1'b0, 1'b1, rd, wr, NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'hFFFE);
    drive(1'b0, 1'b1, rd, wr, NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b1, rd, wr, NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b1, NOP, NOP, NOP, NOP, 32'h0, EN_ALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL saturation #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_reset_and_alive_midflight();
    int n = 0;
    logic [25:0] e, o;
    logic [31:0] rd, wr;
    rd = op3(6'h20, 5'd8, 5'd3, 5'd9);
    wr = op3(6'h20, 5'd3, 5'd1, 5'd2);
    drive(1'b1, 1'b1, rd,   wr,   NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b1, rd,   wr,   NOP, NOP, 32'h0, EN_OFF,   2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, rd,   wr,   NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, HALT, NOP,  NOP, NOP, 32'h0, EN_HALT,  2'b00, 1'b0, 1'b1, 1'b0, 16'h0001);
    drive(1'b1, 1'b1, NOP,  HALT, NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0001);
    drive(1'b0, 1'b1, NOP,  NOP,  NOP, NOP, 32'h0, EN_OFF,   2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, rd,   wr,   NOP, NOP, 32'h0, EN_STALL, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, rd,   wr,   NOP, NOP, 32'h0, EN_OFF,   2'b00, 1'b0, 1'b0, 1'b0, 16'h0001);
    drive(1'b0, 1'b1, NOP,  NOP,  NOP, NOP, 32'h0, EN_OFF,   2'b00, 1'b0, 1'b0, 1'b0, 16'h0001);
    drive(1'b0, 1'b1, NOP,  NOP,  NOP, NOP, 32'h0, EN_ALL,   2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midflight #%0d: got en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h, want en=%b pcsel=%b bub=%b sq=%b halt=%b cnt=%h",
                 n, o[25:21], o[20:19], o[18], o[17], o[16], o[15:0], e[25:21], e[20:19], e[18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  initial begin
    bus.alive     = 1'b0;
    bus.instr_rfr = NOP;
    bus.instr_alu = NOP;
    bus.instr_dm  = NOP;
    bus.instr_rfw = NOP;
    bus.pc_addr   = 32'h0;
    test_reset();
    test_independent();
    test_raw_stall();
    test_r31_and_sources();
    test_branches();
    test_hazard_beats_branch();
    test_halt();
    test_saturation();
    test_reset_and_alive_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
